// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: FSM state encoding,
// opcode constants and IR field positions.
// Opcode map: 0x00-0x0A register-class ALU ops, 0x0F MUL, 0x10 DIV,
// 0x1B HALT; every other opcode is illegal.
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HALT
  } state_t;

  // IR field bit positions
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  // Register-class ALU opcodes
  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_SHR  = 5'h04;
  localparam logic [4:0] OP_SHL  = 5'h05;
  localparam logic [4:0] OP_SHRA = 5'h06;
  localparam logic [4:0] OP_ROR  = 5'h07;
  localparam logic [4:0] OP_ROL  = 5'h08;
  localparam logic [4:0] OP_NEG  = 5'h09;
  localparam logic [4:0] OP_NOT  = 5'h0A;

  // Mul/div-class and control opcodes
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_HALT = 5'h1B;

  function automatic logic is_reg_op(input logic [4:0] op);
    return (op <= OP_NOT);
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/control_sequencer_reg_decoder.sv
// 4-to-16 one-hot register-file enable decoder.
// Ports:
//   en     - when low, no output bit is set
//   sel    - register number (0 selects R0)
//   onehot - bit n high selects Rn
module reg_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute control sequencer for a simple datapath.
// Fetch: T0 (PC->MAR, PC++), T1 (memory read, waits on mem_rdy),
// T2 (MDR->IR). Execute: T3 (rb->Y), T4 (ALU, rc->Z), T5 (Zlow->ra or LO),
// T6 (Zhigh->HI, mul/div only). Illegal and HALT opcodes park in HALT
// until clear.
// Ports:
//   clock, clear          - clock, synchronous active-high reset
//   run                   - start/continue execution (sampled in IDLE, T5/T6)
//   mem_rdy               - memory read data valid
//   ir                    - IR contents: op[31:27] ra[26:23] rb[22:19] rc[18:15]
//   PCout..HIin           - datapath strobes
//   Rin, Rout             - one-hot register-file enables
//   alu_op                - opcode during T4, else 0
//   halted                - high while in HALT
// Configuration macro: SEQ_MULDIV_EN enables the MUL/DIV opcode class.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        memRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_op,
  output logic        halted
);

  state_t      state;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        muldiv;
  logic        legal;
  logic        rin_en, rout_en;
  logic [3:0]  rin_sel, rout_sel;
  logic        unused_ir_bits;

  assign opcode = ir[OP_MSB:OP_LSB];
  assign ra     = ir[RA_MSB:RA_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];
  assign rc     = ir[RC_MSB:RC_LSB];
  assign unused_ir_bits = ^ir[14:0];

`ifdef SEQ_MULDIV_EN
  assign muldiv = is_muldiv_op(opcode);
`else
  assign muldiv = 1'b0;
`endif

  assign legal = is_reg_op(opcode) || muldiv;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (run) state <= T0;
        T0:   state <= T1;
        T1:   if (mem_rdy) state <= T2;
        T2:   state <= T3;
        T3:   state <= legal ? T4 : HALT;
        T4:   state <= T5;
        T5:   begin
          if (muldiv) state <= T6;
          else        state <= run ? T0 : IDLE;
        end
        T6:   state <= run ? T0 : IDLE;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from the registered state plus ir: the IR is loaded at
  // the end of T2, so its fields are only valid from T3 onward and cannot
  // be pre-registered alongside the next state.
  always_comb begin
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    memRead  = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    alu_op   = '0;
    halted   = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rin_sel  = '0;
    rout_sel = '0;
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        memRead = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (legal) begin
          Yin      = 1'b1;
          rout_en  = 1'b1;
          rout_sel = rb;
        end
      end
      T4: begin
        Zin      = 1'b1;
        rout_en  = 1'b1;
        rout_sel = rc;
        alu_op   = opcode;
      end
      T5: begin
        Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
        if (muldiv) begin
          LOin = 1'b1;
        end else begin
          rin_en  = 1'b1;
          rin_sel = ra;
        end
`else
        rin_en  = 1'b1;
        rin_sel = ra;
`endif
      end
      T6: begin
`ifdef SEQ_MULDIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
`endif
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  reg_decoder u_rin_dec (
    .en     (rin_en),
    .sel    (rin_sel),
    .onehot (Rin)
  );

  reg_decoder u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer. Each observation
// packs {strobes[13:0], Rin, Rout, alu_op}; strobes are ordered
// {PCout,IncPC,MARin,memRead,MDRin,MDRout,IRin,Yin,Zin,Zlowout,Zhighout,
//  LOin,HIin,halted}.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic        PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  localparam logic [13:0] P_NONE = 14'b00000000000000;
  localparam logic [13:0] P_T0   = 14'b11100000000000;
  localparam logic [13:0] P_T1   = 14'b00011000000000;
  localparam logic [13:0] P_T2   = 14'b00000110000000;
  localparam logic [13:0] P_T3   = 14'b00000001000000;
  localparam logic [13:0] P_T4   = 14'b00000000100000;
  localparam logic [13:0] P_T5   = 14'b00000000010000;
  localparam logic [13:0] P_T5M  = 14'b00000000010100;
  localparam logic [13:0] P_T6   = 14'b00000000001010;
  localparam logic [13:0] P_HALT = 14'b00000000000001;

  localparam logic [50:0] ZERO = '0;

  // SHRA R1,R2,R3
  localparam logic [31:0] IR_SHRA = 32'h3091_8000;
  // MUL R4,R5,R6
  localparam logic [31:0] IR_MUL  = {5'h0F, 4'd4, 4'd5, 4'd6, 15'd0};
  localparam logic [31:0] IR_ILL  = {5'h1F, 27'd0};
  localparam logic [31:0] IR_HALT = {5'h1B, 4'd1, 4'd2, 4'd3, 15'd0};
  // ADD R0,R0,R0
  localparam logic [31:0] IR_ADD0 = 32'h0000_0000;

  control_sequencer dut (
    .clock    (clock),
    .clear    (clear),
    .run      (run),
    .mem_rdy  (mem_rdy),
    .ir       (ir),
    .PCout    (PCout),
    .IncPC    (IncPC),
    .MARin    (MARin),
    .memRead  (memRead),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .IRin     (IRin),
    .Yin      (Yin),
    .Zin      (Zin),
    .Zlowout  (Zlowout),
    .Zhighout (Zhighout),
    .LOin     (LOin),
    .HIin     (HIin),
    .Rin      (Rin),
    .Rout     (Rout),
    .alu_op   (alu_op),
    .halted   (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [50:0] snap();
    return {PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin,
            Zlowout, Zhighout, LOin, HIin, halted, Rin, Rout, alu_op};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    run   = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // From IDLE, walk the fetch so the DUT sits in T3 on return; run is
  // dropped after T0 since it must be ignored there.
  task automatic to_t3();
    mem_rdy = 1'b1;
    run     = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    logic [50:0] exp;
    ir      = IR_SHRA;
    mem_rdy = 1'b1;
    run     = 1'b1;
    clear   = 1'b1;
    step();
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL reset_clear_run got=%h exp=%h", snap(), ZERO);
    end
    checks++;
    step();
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", snap(), ZERO);
    end
    checks++;
    clear = 1'b0;
    step();
    exp = {P_T0, 16'h0, 16'h0, 5'd0};
    if (snap() !== exp) begin
      failures++;
      $display("FAIL reset_then_t0 got=%h exp=%h", snap(), exp);
    end
    checks++;
    do_clear();
    step();
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL idle_hold_run0 got=%h exp=%h", snap(), ZERO);
    end
    checks++;
  endtask

  task automatic test_shra();
    logic [50:0] exp_tab [6];
    exp_tab[0] = {P_T0, 16'h0000, 16'h0000, 5'd0};
    exp_tab[1] = {P_T1, 16'h0000, 16'h0000, 5'd0};
    exp_tab[2] = {P_T2, 16'h0000, 16'h0000, 5'd0};
    exp_tab[3] = {P_T3, 16'h0000, 16'h0004, 5'd0};
    exp_tab[4] = {P_T4, 16'h0000, 16'h0008, 5'd6};
    exp_tab[5] = {P_T5, 16'h0002, 16'h0000, 5'd0};
    do_clear();
    ir      = IR_SHRA;
    mem_rdy = 1'b1;
    run     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (snap() !== exp_tab[i]) begin
        failures++;
        $display("FAIL shra_cycle%0d got=%h exp=%h", i, snap(), exp_tab[i]);
      end
      checks++;
      if (i == 5) run = 1'b0;
    end
    step();
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL shra_t5_run0_idle got=%h exp=%h", snap(), ZERO);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [50:0] exp;
    do_clear();
    ir = IR_SHRA;
    to_t3();
    step();
    step();
    exp = {P_T5, 16'h0002, 16'h0000, 5'd0};
    if (snap() !== exp) begin
      failures++;
      $display("FAIL b2b_t5_despite_run0 got=%h exp=%h", snap(), exp);
    end
    checks++;
    run = 1'b1;
    step();
    exp = {P_T0, 16'h0, 16'h0, 5'd0};
    if (snap() !== exp) begin
      failures++;
      $display("FAIL b2b_t0_after_t5 got=%h exp=%h", snap(), exp);
    end
    checks++;
    step();
    exp = {P_T1, 16'h0, 16'h0, 5'd0};
    if (snap() !== exp) begin
      failures++;
      $display("FAIL b2b_t1 got=%h exp=%h", snap(), exp);
    end
    checks++;
  endtask

  task automatic test_mem_wait();
    logic [50:0] exp;
    do_clear();
    ir      = IR_SHRA;
    mem_rdy = 1'b0;
    run     = 1'b1;
    step();
    run = 1'b0;
    exp = {P_T1, 16'h0, 16'h0, 5'd0};
    for (int i = 0; i < 4; i++) begin
      step();
      if (snap() !== exp) begin
        failures++;
        $display("FAIL memwait_t1_cycle%0d got=%h exp=%h", i, snap(), exp);
      end
      checks++;
      if (i == 3) mem_rdy = 1'b1;
    end
    step();
    exp = {P_T2, 16'h0, 16'h0, 5'd0};
    if (snap() !== exp) begin
      failures++;
      $display("FAIL memwait_t2 got=%h exp=%h", snap(), exp);
    end
    checks++;
  endtask

  task automatic test_clear_mid();
    logic [50:0] exp;
    do_clear();
    ir = IR_SHRA;
    to_t3();
    step();
    exp = {P_T4, 16'h0000, 16'h0008, 5'd6};
    if (snap() !== exp) begin
      failures++;
      $display("FAIL clr_t4_pre got=%h exp=%h", snap(), exp);
    end
    checks++;
    clear = 1'b1;
    step();
    clear = 1'b0;
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL clr_t4_idle got=%h exp=%h", snap(), ZERO);
    end
    checks++;
    step();
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL clr_t4_no_rin got=%h exp=%h", snap(), ZERO);
    end
    checks++;
    mem_rdy = 1'b0;
    run     = 1'b1;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    run   = 1'b0;
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL clr_t1_wait got=%h exp=%h", snap(), ZERO);
    end
    checks++;
  endtask

  task automatic test_muldiv();
    logic [50:0] exp_tab [5];
`ifdef SEQ_MULDIV_EN
    exp_tab[0] = {P_T3,  16'h0000, 16'h0020, 5'd0};
    exp_tab[1] = {P_T4,  16'h0000, 16'h0040, 5'd15};
    exp_tab[2] = {P_T5M, 16'h0000, 16'h0000, 5'd0};
    exp_tab[3] = {P_T6,  16'h0000, 16'h0000, 5'd0};
    exp_tab[4] = ZERO;
`else
    exp_tab[0] = ZERO;
    exp_tab[1] = {P_HALT, 16'h0, 16'h0, 5'd0};
    exp_tab[2] = {P_HALT, 16'h0, 16'h0, 5'd0};
    exp_tab[3] = {P_HALT, 16'h0, 16'h0, 5'd0};
    exp_tab[4] = {P_HALT, 16'h0, 16'h0, 5'd0};
`endif
    do_clear();
    ir = IR_MUL;
    to_t3();
    for (int i = 0; i < 5; i++) begin
      if (snap() !== exp_tab[i]) begin
        failures++;
        $display("FAIL muldiv_cycle%0d got=%h exp=%h", i, snap(), exp_tab[i]);
      end
      checks++;
      if (i < 4) step();
    end
  endtask

  task automatic test_illegal();
    logic [50:0] exp;
    do_clear();
    ir = IR_ILL;
    to_t3();
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL illegal_t3_quiet got=%h exp=%h", snap(), ZERO);
    end
    checks++;
    exp = {P_HALT, 16'h0, 16'h0, 5'd0};
    for (int i = 0; i < 3; i++) begin
      step();
      if (snap() !== exp) begin
        failures++;
        $display("FAIL illegal_halted%0d got=%h exp=%h", i, snap(), exp);
      end
      checks++;
      run = ~run;
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    run   = 1'b0;
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL illegal_clear got=%h exp=%h", snap(), ZERO);
    end
    checks++;
  endtask

  task automatic test_halt_op();
    logic [50:0] exp;
    do_clear();
    ir = IR_HALT;
    to_t3();
    if (snap() !== ZERO) begin
      failures++;
      $display("FAIL haltop_t3_quiet got=%h exp=%h", snap(), ZERO);
    end
    checks++;
    step();
    exp = {P_HALT, 16'h0, 16'h0, 5'd0};
    if (snap() !== exp) begin
      failures++;
      $display("FAIL haltop_halted got=%h exp=%h", snap(), exp);
    end
    checks++;
  endtask

  task automatic test_r0();
    logic [50:0] exp_tab [3];
    exp_tab[0] = {P_T3, 16'h0000, 16'h0001, 5'd0};
    exp_tab[1] = {P_T4, 16'h0000, 16'h0001, 5'd0};
    exp_tab[2] = {P_T5, 16'h0001, 16'h0000, 5'd0};
    do_clear();
    ir = IR_ADD0;
    to_t3();
    for (int i = 0; i < 3; i++) begin
      if (snap() !== exp_tab[i]) begin
        failures++;
        $display("FAIL r0_cycle%0d got=%h exp=%h", i, snap(), exp_tab[i]);
      end
      checks++;
      if (i < 2) step();
    end
  endtask

  initial begin
    clear   = 1'b1;
    run     = 1'b0;
    mem_rdy = 1'b0;
    ir      = '0;
    test_reset();
    test_shra();
    test_back_to_back();
    test_mem_wait();
    test_clear_mid();
    test_muldiv();
    test_illegal();
    test_halt_op();
    test_r0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
